// File: rtl/sub_flag_pkg.sv
// Shared constants and types for the subtractor result/flag stage.
package sub_flag_pkg;

  localparam int FLAGS_W = 4;
  localparam int FLAG_N  = 3;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_C  = 1;
  localparam int FLAG_V  = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/sub_flag_calc.sv
// Combinational N/Z/C/V derivation for a - b computed with c_in tied to 1.
module sub_flag_calc
  import sub_flag_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]       i_a,
  input  logic [N-1:0]       i_b,
  input  logic [N-1:0]       i_diff,
  input  logic               i_cout,
  output logic [FLAGS_W-1:0] o_flags
);

  // Only the sign bits of the operands matter; full buses keep the interface reusable.
  logic w_unused_bits;
  assign w_unused_bits = ^{i_a[N-2:0], i_b[N-2:0]};

  // Flag vector from operand signs, difference and carry-out.
  always_comb begin
    o_flags         = {FLAGS_W{1'b0}};
    o_flags[FLAG_N] = i_diff[N-1];
    o_flags[FLAG_Z] = (i_diff == {N{1'b0}});
    o_flags[FLAG_C] = i_cout;
    o_flags[FLAG_V] = (i_a[N-1] != i_b[N-1]) && (i_diff[N-1] != i_a[N-1]);
  end

endmodule

// File: rtl/sub_flag_stage.sv
// Registered result/flag stage with a 2-entry skid buffer behind the subtractor.
// Optional sticky overflow flag when SUB_FLAG_STICKY_V_EN is defined.
module sub_flag_stage
  import sub_flag_pkg::*;
#(
  parameter int N = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_a,
  input  logic [N-1:0]       in_b,
  input  logic [N-1:0]       in_diff,
  input  logic               in_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_diff,
  output logic [FLAGS_W-1:0] out_flags
`ifdef SUB_FLAG_STICKY_V_EN
  ,
  input  logic               sticky_clr,
  output logic               sticky_v
`endif
);

  localparam int ENT_W = N + FLAGS_W;

  logic [FLAGS_W-1:0] w_flags;
  logic [ENT_W-1:0]   w_entry;
  logic               w_push;
  logic               w_pop;
  state_e             w_next_state;

  state_e             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [ENT_W-1:0]   r_head;
  logic [ENT_W-1:0]   r_skid;

  sub_flag_calc #(.N(N)) u_calc (
    .i_a     (in_a),
    .i_b     (in_b),
    .i_diff  (in_diff),
    .i_cout  (in_cout),
    .o_flags (w_flags)
  );

  assign w_entry   = {in_diff, w_flags};
  assign w_push    = in_valid & r_in_ready;
  assign w_pop     = r_out_valid & out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_diff  = r_head[ENT_W-1:FLAGS_W];
  assign out_flags = r_head[FLAGS_W-1:0];

  // Next occupancy state from this cycle's push/pop.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY: begin
        if (w_push) w_next_state = HALF;
        else        w_next_state = EMPTY;
      end
      HALF: begin
        if (w_push && !w_pop)      w_next_state = FULL;
        else if (w_pop && !w_push) w_next_state = EMPTY;
        else                       w_next_state = HALF;
      end
      FULL: begin
        if (w_pop) w_next_state = HALF;
        else       w_next_state = FULL;
      end
      default: w_next_state = EMPTY;
    endcase
  end

  // Skid FSM: state, registered handshakes and the two storage entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_head      <= {ENT_W{1'b0}};
      r_skid      <= {ENT_W{1'b0}};
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= (w_next_state != FULL);
      r_out_valid <= (w_next_state != EMPTY);
      case (r_state)
        EMPTY: begin
          if (w_push) r_head <= w_entry;
        end
        HALF: begin
          if (w_push && w_pop) r_head <= w_entry;
          else if (w_push)     r_skid <= w_entry;
        end
        FULL: begin
          if (w_pop) r_head <= r_skid;
        end
        default: begin
          r_head <= {ENT_W{1'b0}};
          r_skid <= {ENT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef SUB_FLAG_STICKY_V_EN
  logic r_sticky_v;
  assign sticky_v = r_sticky_v;

  // Sticky overflow: set by any popped V=1 result, clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_v <= 1'b0;
    end else if (sticky_clr) begin
      r_sticky_v <= 1'b0;
    end else if (w_pop && r_head[FLAG_V]) begin
      r_sticky_v <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sub_flag_stage.sv
// Directed + random scoreboard bench for sub_flag_stage (N=32).
module tb_sub_flag_stage;

  localparam int N = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic [N-1:0]  in_diff;
  logic          in_cout;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_diff;
  logic [3:0]    out_flags;
`ifdef SUB_FLAG_STICKY_V_EN
  logic          sticky_clr;
  logic          sticky_v;
  logic          exp_sticky;
`endif

  int            total = 0;
  int            bad   = 0;
  logic [N+3:0]  sb[$];
  logic          model_rdy;
  logic [3:0]    cur_flags;

  sub_flag_stage #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_diff   (in_diff),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_flags (out_flags)
`ifdef SUB_FLAG_STICKY_V_EN
    ,
    .sticky_clr(sticky_clr),
    .sticky_v  (sticky_v)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_flags(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] d, input logic c);
    logic z;
    logic v;
    z = (d == {N{1'b0}});
    v = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
    return {d[N-1], z, c, v};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] d, input logic c, input logic [3:0] f);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_diff   = d;
    in_cout   = c;
    cur_flags = f;
  endtask

  task automatic drive_sub(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] d;
    logic         c;
    d = a - b;
    c = (a >= b);
    drive(a, b, d, c, ref_flags(a, b, d, c));
  endtask

  // One clock cycle: compare outputs against the model, then advance both.
  task automatic tick(input string tag);
    logic pop;
    check({tag, "/in_ready"}, 64'(in_ready), 64'(model_rdy));
    check({tag, "/out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0)
      check({tag, "/data"}, 64'({out_diff, out_flags}), 64'(sb[0]));
    pop = (sb.size() != 0) && out_ready;
`ifdef SUB_FLAG_STICKY_V_EN
    if (sticky_clr)           exp_sticky = 1'b0;
    else if (pop && sb[0][0]) exp_sticky = 1'b1;
`endif
    if (pop) void'(sb.pop_front());
    if (in_valid && model_rdy) sb.push_back({in_diff, cur_flags});
    @(posedge clk);
    @(negedge clk);
    model_rdy = (sb.size() != 2);
`ifdef SUB_FLAG_STICKY_V_EN
    check({tag, "/sticky_v"}, 64'(sticky_v), 64'(exp_sticky));
`endif
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/rst_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "/rst_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "/rst_out_diff"},  64'(out_diff),  64'd0);
    check({tag, "/rst_out_flags"}, 64'(out_flags), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_diff   = '0;
    in_cout   = 1'b0;
    out_ready = 1'b0;
    cur_flags = 4'd0;
    model_rdy = 1'b0;
`ifdef SUB_FLAG_STICKY_V_EN
    sticky_clr = 1'b0;
    exp_sticky = 1'b0;
`endif
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick("post_rst");

    // Test-plan flag vectors with literal expectations.
    out_ready = 1'b1;
    drive(32'd5, 32'd3, 32'd2, 1'b1, 4'b0010);                          tick("v5m3");
    drive(32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 4'b1000);                  tick("v3m5");
    drive(32'd7, 32'd7, 32'd0, 1'b1, 4'b0110);                          tick("v7m7");
    drive(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 4'b0011);          tick("vovf");
    idle();                                                             tick("drain0");
    tick("drain1");

    // Backpressure: 10 and 11 fill the buffer, 12 must wait.
    out_ready = 1'b0;
    drive_sub(32'd10, 32'd0); tick("bp10");
    drive_sub(32'd11, 32'd0); tick("bp11");
    drive_sub(32'd12, 32'd0); tick("bp12a");
    tick("bp12b");
    out_ready = 1'b1;
    tick("bp_pop10");
    tick("bp_pop11");
    idle();
    tick("bp_pop12");
    tick("bp_empty");

    // Async reset while FULL discards both entries.
    out_ready = 1'b0;
    drive_sub(32'd20, 32'd1); tick("mr20");
    drive_sub(32'd21, 32'd1); tick("mr21");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    model_rdy = 1'b0;
`ifdef SUB_FLAG_STICKY_V_EN
    exp_sticky = 1'b0;
`endif
    idle();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick("mr_release");
    drive(32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 4'b1000); tick("mr_push");
    idle();
    tick("mr_pop");
    tick("mr_idle");

    // Random traffic with random backpressure.
    for (int i = 0; i < 60; i++) begin
      drive_sub($urandom, $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick("rnd");
    end
    idle();
    out_ready = 1'b1;
    tick("rnd_drain0");
    tick("rnd_drain1");
    tick("rnd_drain2");

`ifdef SUB_FLAG_STICKY_V_EN
    drive(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 4'b0011); tick("st_v1");
    drive(32'd5, 32'd3, 32'd2, 1'b1, 4'b0010);                 tick("st_v0a");
    drive(32'd7, 32'd7, 32'd0, 1'b1, 4'b0110);                 tick("st_v0b");
    drive(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 4'b0011); tick("st_v1b");
    idle();
    sticky_clr = 1'b1;
    tick("st_clr_pop");
    sticky_clr = 1'b0;
    tick("st_after");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
